// File: rtl/wb_bitstream_loader.sv
// Wishbone slave that buffers eFPGA bitstream words and streams frame data into the fabric config port.
// Optional macro BITSTREAM_CHECKSUM_EN adds a trailing XOR checksum word checked after END_WORD.
module wb_bitstream_loader #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          NUM_FRAMES   = 20,
    parameter int          FRAME_WORDS  = 8,
    parameter int          FRAME_ADDR_W = 5,
    parameter logic [31:0] SYNC_WORD    = 32'hFAB0_FAB1,
    parameter logic [31:0] END_WORD     = 32'hFAB0_FFFF
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           wbs_stb_i,
    input  logic                           wbs_cyc_i,
    input  logic                           wbs_we_i,
    input  logic [3:0]                     wbs_sel_i,
    input  logic [31:0]                    wbs_adr_i,
    input  logic [31:0]                    wbs_dat_i,
    output logic                           wbs_ack_o,
    output logic [31:0]                    wbs_dat_o,
    output logic [FRAME_ADDR_W-1:0]        cfg_frame_addr,
    output logic [$clog2(FRAME_WORDS)-1:0] cfg_word_idx,
    output logic [31:0]                    cfg_data,
    output logic                           cfg_valid,
    input  logic                           cfg_ready,
    output logic                           cfg_active,
    output logic                           cfg_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int IDX_W = $clog2(FRAME_WORDS);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;
`ifdef BITSTREAM_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd6;
    localparam logic [2:0] S_TAIL = S_CHK;
`else
    localparam logic [2:0] S_TAIL = S_DONE;
`endif

    logic [2:0]              state_q, state_d;
    logic [31:0]             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        count_q;
    logic [FRAME_ADDR_W-1:0] frame_addr_q, frame_addr_d;
    logic [IDX_W-1:0]        word_idx_q, word_idx_d;
    logic                    ack_q;
    logic [31:0]             dat_q;
    logic [15:0]             status_hi;
`ifdef BITSTREAM_CHECKSUM_EN
    logic [31:0]             acc_q, acc_d;
    assign status_hi = acc_q[15:0];
`else
    assign status_hi = 16'h0000;
`endif

    logic        sel, req, start, data_wr, stall, push, pop, accept;
    logic        empty, full, busy, error;
    logic [1:0]  reg_off;
    logic [31:0] head, status, rd_val;
    logic        unused_ok;

    assign unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[1:0]};

    assign empty   = (count_q == '0);
    assign full    = (count_q == LVL_W'(FIFO_DEPTH));
    assign head    = mem_q[rd_ptr_q];
    assign busy    = (state_q == S_SYNC) || (state_q == S_HDR) || (state_q == S_DATA)
`ifdef BITSTREAM_CHECKSUM_EN
                  || (state_q == S_CHK)
`endif
                  ;
    assign error   = (state_q == S_ERR);
    assign status  = {status_hi, 8'(count_q), 5'd0, error, (state_q == S_DONE), busy};

    // A request is taken only while ack is low, so every access sees exactly one ack pulse.
    assign sel     = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req     = sel && !ack_q;
    assign reg_off = wbs_adr_i[3:2];
    assign start   = req && wbs_we_i && (reg_off == 2'd0) && wbs_dat_i[0];
    assign data_wr = req && wbs_we_i && (reg_off == 2'd2);
    assign stall   = data_wr && busy && full && !pop;
    assign push    = data_wr && busy && !stall;
    assign accept  = req && !stall;
    assign rd_val  = (reg_off == 2'd1) ? status : 32'h0;

    assign cfg_valid = (state_q == S_DATA) && !empty;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        frame_addr_d = frame_addr_q;
        word_idx_d   = word_idx_q;
        pop          = 1'b0;
`ifdef BITSTREAM_CHECKSUM_EN
        acc_d        = acc_q;
`endif
        if (start) begin
            state_d = S_SYNC;
`ifdef BITSTREAM_CHECKSUM_EN
            acc_d   = 32'h0;
`endif
        end else begin
            case (state_q)
                S_SYNC: if (!empty) begin
                    pop = 1'b1;
                    if (head == SYNC_WORD) state_d = S_HDR;
                end
                S_HDR: if (!empty) begin
                    pop = 1'b1;
                    // A legal header is a plain frame number, so one compare covers range and upper bits.
                    if (head == END_WORD)                state_d = S_TAIL;
                    else if (head >= 32'(NUM_FRAMES))    state_d = S_ERR;
                    else begin
                        frame_addr_d = head[FRAME_ADDR_W-1:0];
                        word_idx_d   = '0;
                        state_d      = S_DATA;
                    end
                end
                S_DATA: if (cfg_valid && cfg_ready) begin
                    pop = 1'b1;
`ifdef BITSTREAM_CHECKSUM_EN
                    acc_d = acc_q ^ head;
`endif
                    if (word_idx_q == IDX_W'(FRAME_WORDS - 1)) begin
                        word_idx_d = '0;
                        state_d    = S_HDR;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                    end
                end
`ifdef BITSTREAM_CHECKSUM_EN
                S_CHK: if (!empty) begin
                    pop     = 1'b1;
                    state_d = (head == acc_q) ? S_DONE : S_ERR;
                end
`endif
                default: ;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wbs_dat_i;
    end

    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            frame_addr_q <= '0;
            word_idx_q   <= '0;
            ack_q        <= 1'b0;
            dat_q        <= 32'h0;
`ifdef BITSTREAM_CHECKSUM_EN
            acc_q        <= 32'h0;
`endif
        end else begin
            state_q      <= state_d;
            frame_addr_q <= frame_addr_d;
            word_idx_q   <= word_idx_d;
            ack_q        <= accept;
            dat_q        <= (accept && !wbs_we_i) ? rd_val : 32'h0;
`ifdef BITSTREAM_CHECKSUM_EN
            acc_q        <= acc_d;
`endif
            if (start) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push && !pop)      count_q <= count_q + 1'b1;
                else if (pop && !push) count_q <= count_q - 1'b1;
            end
        end
    end

    assign wbs_ack_o      = ack_q;
    assign wbs_dat_o      = dat_q;
    assign cfg_frame_addr = frame_addr_q;
    assign cfg_word_idx   = word_idx_q;
    assign cfg_data       = cfg_valid ? head : 32'h0;
    assign cfg_active     = busy;
    assign cfg_done       = (state_q == S_DONE);

endmodule

// File: tb/tb_wb_bitstream_loader.sv
// Self-checking bench for wb_bitstream_loader: Wishbone stimulus, scoreboard of expected fabric transfers.
// Honours BITSTREAM_CHECKSUM_EN the same way the design does.
module tb_wb_bitstream_loader;

    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_STATUS = 32'h3000_0004;
    localparam logic [31:0] A_DATA   = 32'h3000_0008;
    localparam logic [31:0] A_RSVD   = 32'h3000_000C;
    localparam logic [31:0] A_OTHER  = 32'h3100_0000;
    localparam logic [31:0] SYNC_W   = 32'hFAB0_FAB1;
    localparam logic [31:0] END_W    = 32'hFAB0_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [4:0]  cfg_frame_addr;
    logic [2:0]  cfg_word_idx;
    logic [31:0] cfg_data;
    logic        cfg_valid, cfg_ready, cfg_active, cfg_done;

    typedef struct {
        logic [4:0]  fa;
        logic [2:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   passed    = 0;
    int   total     = 0;
    int   n_xfer    = 0;
    int   lost_acks = 0;

    always #5 clk = ~clk;

    wb_bitstream_loader dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wbs_stb_i      (stb),
        .wbs_cyc_i      (cyc),
        .wbs_we_i       (we),
        .wbs_sel_i      (sel),
        .wbs_adr_i      (adr),
        .wbs_dat_i      (wdat),
        .wbs_ack_o      (ack),
        .wbs_dat_o      (rdat),
        .cfg_frame_addr (cfg_frame_addr),
        .cfg_word_idx   (cfg_word_idx),
        .cfg_data       (cfg_data),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_active     (cfg_active),
        .cfg_done       (cfg_done)
    );

    // Transfers are sampled on the falling edge; they complete on the following rising edge.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'h0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && cfg_valid) begin
                total++;
                if (cfg_data !== prev_data)
                    $display("FAIL stall_stable: cfg_data %h, held %h", cfg_data, prev_data);
                else passed++;
            end
            if (cfg_valid && cfg_ready) begin
                n_xfer++;
                total++;
                if (sb_q.size() == 0) begin
                    $display("FAIL xfer_unexpected: got fa=%0d idx=%0d data=%h, none expected",
                             cfg_frame_addr, cfg_word_idx, cfg_data);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if ({cfg_frame_addr, cfg_word_idx, cfg_data} !== {e.fa, e.idx, e.data})
                        $display("FAIL xfer: got fa=%0d idx=%0d data=%h, want fa=%0d idx=%0d data=%h",
                                 cfg_frame_addr, cfg_word_idx, cfg_data, e.fa, e.idx, e.data);
                    else passed++;
                end
            end
            prev_stall = cfg_valid && !cfg_ready;
            prev_data  = cfg_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input int budget, output logic [31:0] r, output int cycles,
                             output bit acked);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
        cycles = 0; acked = 1'b0; r = 32'h0;
        while (cycles < budget && !acked) begin
            @(negedge clk);
            cycles++;
            if (ack) begin
                acked = 1'b1;
                r = rdat;
            end
        end
        tick();
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        int c;
        bit k;
        wb_access(a, 1'b1, d, 20, r, c, k);
        if (!k) lost_acks++;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        int c;
        bit k;
        wb_access(a, 1'b0, 32'h0, 20, d, c, k);
        if (!k) lost_acks++;
    endtask

    // Writes SYNC, header, eight data words, END (and checksum when enabled); queues the expected transfers.
    task automatic send_stream(input logic [4:0] fa, input logic [31:0] base, output logic [31:0] x);
        exp_t e;
        x = 32'h0;
        wr(A_DATA, SYNC_W);
        wr(A_DATA, {27'h0, fa});
        for (int i = 0; i < 8; i++) begin
            e.fa = fa; e.idx = 3'(i); e.data = base + 32'(i);
            sb_q.push_back(e);
            x = x ^ e.data;
            wr(A_DATA, e.data);
        end
        wr(A_DATA, END_W);
`ifdef BITSTREAM_CHECKSUM_EN
        wr(A_DATA, x);
`endif
    endtask

    function automatic logic [31:0] status_done(input logic [31:0] x);
`ifdef BITSTREAM_CHECKSUM_EN
        return {x[15:0], 16'h0002};
`else
        return 32'h0000_0002 | (x & 32'h0);
`endif
    endfunction

    task automatic test_reset();
        logic [31:0] r;
        int c;
        bit k;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        total++;
        if ({ack, rdat, cfg_valid, cfg_data, cfg_frame_addr, cfg_word_idx, cfg_active, cfg_done} !== '0)
            $display("FAIL reset_outputs: ack=%b dat=%h valid=%b data=%h fa=%0d idx=%0d act=%b done=%b, want all 0",
                     ack, rdat, cfg_valid, cfg_data, cfg_frame_addr, cfg_word_idx, cfg_active, cfg_done);
        else passed++;
        rd(A_STATUS, r);
        total++; if (r !== 32'h0) $display("FAIL reset_status: got %h want 00000000", r); else passed++;
        rd(A_CTRL, r);
        total++; if (r !== 32'h0) $display("FAIL read_ctrl: got %h want 00000000", r); else passed++;
        rd(A_DATA, r);
        total++; if (r !== 32'h0) $display("FAIL read_data: got %h want 00000000", r); else passed++;
        rd(A_RSVD, r);
        total++; if (r !== 32'h0) $display("FAIL read_rsvd: got %h want 00000000", r); else passed++;
        wb_access(A_OTHER, 1'b0, 32'h0, 6, r, c, k);
        total++; if (k !== 1'b0) $display("FAIL foreign_addr_ack: got ack=%b want 0", k); else passed++;
        total++; if (lost_acks !== 0) $display("FAIL reset_acks: lost %0d want 0", lost_acks); else passed++;
    endtask

    task automatic test_basic();
        logic [31:0] r, x;
        int base;
        base = n_xfer;
        cfg_ready = 1'b1;
        wr(A_CTRL, 32'h1);
        wr(A_DATA, 32'h1234_5678);
        send_stream(5'd3, 32'h1, x);
        repeat (6) tick();
        total++; if (n_xfer - base !== 8) $display("FAIL basic_xfers: got %0d want 8", n_xfer - base); else passed++;
        total++; if (sb_q.size() !== 0) $display("FAIL basic_drain: %0d left want 0", sb_q.size()); else passed++;
        total++;
        if ({cfg_done, cfg_active} !== 2'b10) $display("FAIL basic_done: done,active=%b want 10", {cfg_done, cfg_active});
        else passed++;
        rd(A_STATUS, r);
        total++; if (r !== status_done(x)) $display("FAIL basic_status: got %h want %h", r, status_done(x)); else passed++;
        total++; if (lost_acks !== 0) $display("FAIL basic_acks: lost %0d want 0", lost_acks); else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] r, x;
        int c;
        bit k;
        exp_t e;
        x = 32'h0;
        cfg_ready = 1'b0;
        wr(A_CTRL, 32'h1);
        wr(A_DATA, 32'h1234_5678);
        wr(A_DATA, SYNC_W);
        wr(A_DATA, 32'h3);
        for (int i = 1; i <= 5; i++) begin
            e.fa = 5'd3; e.idx = 3'(i - 1); e.data = 32'(i);
            sb_q.push_back(e);
            x = x ^ e.data;
            if (i < 5) wr(A_DATA, e.data);
        end
        repeat (2) tick();
        rd(A_STATUS, r);
        total++; if (r !== 32'h0000_0401) $display("FAIL bp_level: got %h want 00000401", r); else passed++;
        total++;
        if ({cfg_valid, cfg_word_idx, cfg_data} !== {1'b1, 3'd0, 32'h1})
            $display("FAIL bp_head: valid=%b idx=%0d data=%h want 1/0/00000001", cfg_valid, cfg_word_idx, cfg_data);
        else passed++;
        fork
            wb_access(A_DATA, 1'b1, 32'h5, 20, r, c, k);
            begin
                repeat (4) tick();
                cfg_ready = 1'b1;
            end
        join
        total++;
        if (k !== 1'b1 || c !== 6) $display("FAIL bp_ack_timing: acked=%b after %0d edges want 1 after 6", k, c);
        else passed++;
        for (int i = 6; i <= 8; i++) begin
            e.fa = 5'd3; e.idx = 3'(i - 1); e.data = 32'(i);
            sb_q.push_back(e);
            x = x ^ e.data;
            wr(A_DATA, e.data);
        end
        wr(A_DATA, END_W);
`ifdef BITSTREAM_CHECKSUM_EN
        wr(A_DATA, x);
`endif
        repeat (6) tick();
        total++; if (sb_q.size() !== 0) $display("FAIL bp_drain: %0d left want 0", sb_q.size()); else passed++;
        total++; if (cfg_done !== 1'b1) $display("FAIL bp_done: got %b want 1", cfg_done); else passed++;
        total++; if (lost_acks !== 0) $display("FAIL bp_acks: lost %0d want 0", lost_acks); else passed++;
    endtask

    task automatic test_bad_header();
        logic [31:0] r, x;
        int base;
        base = n_xfer;
        cfg_ready = 1'b1;
        wr(A_CTRL, 32'h1);
        wr(A_DATA, SYNC_W);
        wr(A_DATA, 32'h0000_0014);
        wr(A_DATA, 32'h0000_00AA);
        repeat (3) tick();
        rd(A_STATUS, r);
        total++; if (r !== 32'h0000_0004) $display("FAIL err_status: got %h want 00000004", r); else passed++;
        total++;
        if ({cfg_active, cfg_valid, cfg_done} !== 3'b000)
            $display("FAIL err_outputs: act,valid,done=%b want 000", {cfg_active, cfg_valid, cfg_done});
        else passed++;
        total++; if (n_xfer !== base) $display("FAIL err_xfers: got %0d want 0", n_xfer - base); else passed++;
        wr(A_CTRL, 32'h1);
        send_stream(5'd19, 32'hA5A5_0000, x);
        repeat (6) tick();
        rd(A_STATUS, r);
        total++; if (r !== status_done(x)) $display("FAIL err_recover: got %h want %h", r, status_done(x)); else passed++;
        total++; if (n_xfer - base !== 8) $display("FAIL err_recover_xfers: got %0d want 8", n_xfer - base); else passed++;
    endtask

    task automatic test_reset_midload();
        logic [31:0] r;
        int base;
        exp_t e;
        cfg_ready = 1'b1;
        wr(A_CTRL, 32'h1);
        wr(A_DATA, SYNC_W);
        wr(A_DATA, 32'h5);
        for (int i = 0; i < 3; i++) begin
            e.fa = 5'd5; e.idx = 3'(i); e.data = 32'hC0 + 32'(i);
            sb_q.push_back(e);
            wr(A_DATA, e.data);
        end
        repeat (2) tick();
        cfg_ready = 1'b0;
        wr(A_DATA, 32'hC3);
        tick();
        total++;
        if ({cfg_valid, cfg_word_idx, cfg_data} !== {1'b1, 3'd3, 32'hC3})
            $display("FAIL midload_pre: valid=%b idx=%0d data=%h want 1/3/000000c3", cfg_valid, cfg_word_idx, cfg_data);
        else passed++;
        rst = 1'b1;
        tick();
        total++;
        if ({ack, rdat, cfg_valid, cfg_data, cfg_frame_addr, cfg_word_idx, cfg_active, cfg_done} !== '0)
            $display("FAIL midload_reset: valid=%b data=%h fa=%0d idx=%0d act=%b done=%b, want all 0",
                     cfg_valid, cfg_data, cfg_frame_addr, cfg_word_idx, cfg_active, cfg_done);
        else passed++;
        rst = 1'b0;
        cfg_ready = 1'b1;
        base = n_xfer;
        wr(A_DATA, 32'h55);
        repeat (3) tick();
        rd(A_STATUS, r);
        total++; if (r !== 32'h0) $display("FAIL post_reset_status: got %h want 00000000", r); else passed++;
        total++; if (n_xfer !== base) $display("FAIL post_reset_xfer: got %0d want 0", n_xfer - base); else passed++;
        total++; if (lost_acks !== 0) $display("FAIL midload_acks: lost %0d want 0", lost_acks); else passed++;
    endtask

`ifdef BITSTREAM_CHECKSUM_EN
    task automatic test_checksum();
        logic [31:0] r, x;
        exp_t e;
        cfg_ready = 1'b1;
        wr(A_CTRL, 32'h1);
        send_stream(5'd3, 32'h1, x);
        repeat (6) tick();
        rd(A_STATUS, r);
        total++; if (r !== 32'h0008_0002) $display("FAIL chk_good: got %h want 00080002", r); else passed++;
        wr(A_CTRL, 32'h1);
        wr(A_DATA, SYNC_W);
        wr(A_DATA, 32'h3);
        for (int i = 1; i <= 8; i++) begin
            e.fa = 5'd3; e.idx = 3'(i - 1); e.data = 32'(i);
            sb_q.push_back(e);
            wr(A_DATA, e.data);
        end
        wr(A_DATA, END_W);
        wr(A_DATA, 32'h9);
        repeat (6) tick();
        rd(A_STATUS, r);
        total++; if (r !== 32'h0008_0004) $display("FAIL chk_bad: got %h want 00080004", r); else passed++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
        adr = 32'h0; wdat = 32'h0; cfg_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_bad_header();
        test_reset_midload();
`ifdef BITSTREAM_CHECKSUM_EN
        test_checksum();
`endif
        total++;
        if (sb_q.size() !== 0) $display("FAIL final_scoreboard: %0d left want 0", sb_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_bitstream_loader.md
Name: wb_bitstream_loader

Overview:
- Wishbone slave on the user-area bus that receives eFPGA configuration bitstream words from the management core.
- Buffers the words in a small FIFO and parses sync, frame-header and end markers.
- Streams frame data words, with a ready/valid handshake, into the eFPGA_top configuration port.
- Sits directly upstream of eFPGA_top inside user_project_wrapper.

Parameters:
- BASE_ADDR, 32'h3000_0000, register block base; decode compares wbs_adr_i[31:4] with BASE_ADDR[31:4].
- FIFO_DEPTH, 4, word FIFO depth; must be a power of two, 2 or more.
- NUM_FRAMES, 20, number of fabric frames; legal frame address range is 0..NUM_FRAMES-1.
- FRAME_WORDS, 8, data words per frame.
- FRAME_ADDR_W, 5, width of cfg_frame_addr.
- SYNC_WORD, 32'hFAB0_FAB1, stream start marker.
- END_WORD, 32'hFAB0_FFFF, stream end marker.

Ports:
- wb_clk_i  in  1  clock; everything is on the rising edge.
- wb_rst_i  in  1  synchronous reset, active-high.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle and write-enable.
- wbs_sel_i  in  4  byte selects; ignored, all accesses are full-word.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- cfg_frame_addr  out  FRAME_ADDR_W  frame currently being loaded.
- cfg_word_idx  out  $clog2(FRAME_WORDS)  index of cfg_data within the frame.
- cfg_data  out  32  configuration word.
- cfg_valid  out  1  cfg_data is valid.
- cfg_ready  in  1  fabric accepts the word.
- cfg_active  out  1  a load is in progress.
- cfg_done  out  1  the load completed successfully.

Behaviour:
- Reset: wbs_ack_o=0, wbs_dat_o=0, cfg_valid=0, cfg_data=0, cfg_frame_addr=0, cfg_word_idx=0, cfg_active=0, cfg_done=0. FIFO is empty, the error flag is clear, FSM is in IDLE.
- Reset asserted mid-load aborts the load at once: no further cfg_valid, nothing is retained.

Register map (word offset = wbs_adr_i[3:2]):
- 0 CTRL: write bit0=1 is START. START flushes the FIFO, clears done and error, zeroes the checksum and moves the FSM to SYNC. Reads return 0.
- 1 STATUS (read-only): bit0 = busy (cfg_active), bit1 = done, bit2 = error, bits[15:8] = FIFO level, zero-extended.
- 2 DATA (write-only): pushes wbs_dat_i into the FIFO. Reads return 0.
- 3: reserved; reads return 0, writes are ignored.

Wishbone:
- Selected when stb & cyc & address match. Unselected cycles are never acked.
- Ack is a one-cycle pulse, one cycle after select; it deasserts for at least one cycle between accesses.
- A DATA write while the FIFO is full withholds ack until a pop frees space; the push and the ack then occur in the same cycle. A pop and a push in the same cycle are both allowed when full.
- DATA writes in IDLE, DONE or ERR are acked and discarded, never pushed.

FSM (the FIFO head is popped only in SYNC, HDR, DATA and CHK):
- IDLE: waits for START.
- SYNC: pops one word per cycle while non-empty. A word equal to SYNC_WORD moves to HDR; any other word is discarded.
- HDR: pops one word.
  - Word equal to END_WORD goes to DONE (or CHK when BITSTREAM_CHECKSUM_EN is defined).
  - Otherwise cfg_frame_addr takes word[FRAME_ADDR_W-1:0], cfg_word_idx becomes 0, and the FSM goes to DATA.
  - If word[FRAME_ADDR_W-1:0] >= NUM_FRAMES, or any of word[31:FRAME_ADDR_W] is non-zero, go to ERR.
- DATA:
  - cfg_valid = FIFO non-empty; cfg_data = FIFO head.
  - On cfg_valid & cfg_ready: pop the word, increment cfg_word_idx. Transferring the word at index FRAME_WORDS-1 returns the FSM to HDR.
  - cfg_valid never drops without a transfer unless the FIFO empties; cfg_data is stable while valid & !ready.
- DONE: cfg_done=1, cfg_active=0. Stays until START.
- ERR: error=1, cfg_active=0, cfg_valid=0. Sticky until START or reset.
- cfg_active=1 in SYNC, HDR, DATA and CHK.
- START in any state restarts from SYNC; START has priority over a simultaneous pop.

Optional Feature:
- Macro BITSTREAM_CHECKSUM_EN.
- Defined:
  - A 32-bit XOR accumulator folds in every transferred frame data word.
  - After END_WORD the FSM enters CHK and pops one more word. If it equals the accumulator, go to DONE; otherwise go to ERR.
  - STATUS bits[31:16] read the accumulator's low 16 bits.
- Undefined: no CHK state and no accumulator; END_WORD goes directly to DONE; STATUS bits[31:16] read 0.

Test Plan:
- Reset, then read STATUS -> 0x0000_0000; CTRL, DATA and offset 3 all read 0; no ack on a non-matching address 0x3100_0000.
- START; write 0x1234_5678, FAB0_FAB1, 0x0000_0003, eight words 0x1..0x8, FAB0_FFFF with cfg_ready=1 -> eight cfg_valid transfers with frame_addr=3 and idx 0..7 carrying data 1..8; STATUS = 0x2; cfg_done=1.
- Same stream with cfg_ready=0: the fifth DATA write has its ack withheld (FIFO level 4). Raise cfg_ready -> ack arrives in the same cycle as the first pop; data order is preserved.
- Header 0x0000_0014 (20 = NUM_FRAMES) -> ERR, STATUS = 0x4, no cfg_valid. Then START plus a valid stream -> error cleared, done.
- Assert wb_rst_i after the 3rd data word of a frame -> all outputs return to reset values next cycle; a later DATA write without START is acked and discarded.
- With BITSTREAM_CHECKSUM_EN, data 1..8 (XOR = 0x8): trailing checksum 0x8 -> done; trailing checksum 0x9 -> error.
